// File: rtl/buff_mult_arr_pipe_if.sv
// ---------------------------------------------------------------------------
// buff_mult_arr_pipe_if
// Bundles the operand handshake, the weight-buffer write port and the result
// handshake of the buffer-multiplier lane array.
//
//   in_valid / in_ready   operand word handshake
//   in_a                  LANES x DATA_WID signed operands, lane 0 in the LSBs
//   in_mode               0 = MULT, 1 = MAC
//   in_acc_clr            MAC only: restart the accumulator with this product
//   in_state              PE state tag travelling with the word
//   rd_addr               shared weight-buffer read address
//   wr_en / wr_addr /     per-lane write enables, shared address, broadcast
//   wr_data               write data
//   out_valid / out_ready result word handshake
//   out_data              LANES x DATA_WID signed results
//   out_state             tag aligned with out_data
//
// slave  : view taken by the lane array
// master : view taken by whoever drives the array
// ---------------------------------------------------------------------------
interface buff_mult_arr_pipe_if #(
    parameter int DATA_WID = 16,
    parameter int LANES    = 8,
    parameter int ADDR_B   = 4,
    parameter int STATE_B  = 3
) ();

    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WID-1:0]   in_a;
    logic                        in_mode;
    logic                        in_acc_clr;
    logic [STATE_B-1:0]          in_state;
    logic [ADDR_B-1:0]           rd_addr;
    logic [LANES-1:0]            wr_en;
    logic [ADDR_B-1:0]           wr_addr;
    logic [DATA_WID-1:0]         wr_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WID-1:0]   out_data;
    logic [STATE_B-1:0]          out_state;

    modport slave (
        input  in_valid, in_a, in_mode, in_acc_clr, in_state, rd_addr,
               wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_data, out_state
    );

    modport master (
        output in_valid, in_a, in_mode, in_acc_clr, in_state, rd_addr,
               wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_data, out_state
    );

endinterface

// File: rtl/buff_mult_arr_pipe.sv
// ---------------------------------------------------------------------------
// buff_mult_arr_pipe
// Array of LANES buffer-multiplier lanes. Each lane owns a DEPTH-word weight
// buffer; an accepted word multiplies every lane's operand by the word at the
// shared read address, rescales by FRAC_B, saturates, and optionally
// accumulates. Three register stages (accept, multiply, output) advance
// together whenever the output register is empty or being drained.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (clears pipeline, accumulators and
//          buffers)
//   bus    buff_mult_arr_pipe_if.slave handshake / buffer-write bundle
// ---------------------------------------------------------------------------
module buff_mult_arr_pipe #(
    parameter int DATA_WID = 16,
    parameter int LANES    = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_B   = 4,
    parameter int FRAC_B   = 8,
    parameter int STATE_B  = 3
) (
    input  logic clk,
    input  logic reset,
    buff_mult_arr_pipe_if.slave bus
);

    localparam int PW = 2 * DATA_WID;

    localparam logic signed [PW-1:0] P_MAX = {{(DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {{(DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};
    localparam logic signed [DATA_WID-1:0] D_MAX = {1'b0, {(DATA_WID-1){1'b1}}};
    localparam logic signed [DATA_WID-1:0] D_MIN = {1'b1, {(DATA_WID-1){1'b0}}};

    logic adv;

    logic signed [DATA_WID-1:0] wbuf [LANES][DEPTH];

    logic                       s0_valid;
    logic                       s0_mode;
    logic                       s0_clr;
    logic [STATE_B-1:0]         s0_state;
    logic signed [DATA_WID-1:0] s0_a [LANES];
    logic signed [DATA_WID-1:0] s0_w [LANES];

    logic                       s1_valid;
    logic                       s1_mode;
    logic                       s1_clr;
    logic [STATE_B-1:0]         s1_state;
    logic signed [PW-1:0]       s1_prod [LANES];

    logic signed [PW-1:0]       shifted  [LANES];
    logic signed [DATA_WID-1:0] prod_sat [LANES];
    logic signed [DATA_WID-1:0] acc_base [LANES];
    logic signed [DATA_WID:0]   sum      [LANES];
    logic signed [DATA_WID-1:0] mac_res  [LANES];
    logic signed [DATA_WID-1:0] result   [LANES];

    logic signed [DATA_WID-1:0] acc [LANES];

    logic                       out_valid_q;
    logic [LANES*DATA_WID-1:0]  out_data_q;
    logic [STATE_B-1:0]         out_state_q;

    // The whole pipe moves as one; a stalled full output register freezes it.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_state = out_state_q;

    // Weight buffers: written regardless of the handshake. The S0 read of the
    // same edge samples the pre-write word, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < LANES; l++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    wbuf[l][d] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (bus.wr_en[l]) begin
                    wbuf[l][bus.wr_addr] <= bus.wr_data;
                end
            end
        end
    end

    // S0: capture the operand word (or a bubble) and the buffered weight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            s0_mode  <= 1'b0;
            s0_clr   <= 1'b0;
            s0_state <= '0;
            for (int l = 0; l < LANES; l++) begin
                s0_a[l] <= '0;
                s0_w[l] <= '0;
            end
        end else if (adv) begin
            s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s0_mode  <= bus.in_mode;
                s0_clr   <= bus.in_acc_clr;
                s0_state <= bus.in_state;
                for (int l = 0; l < LANES; l++) begin
                    s0_a[l] <= bus.in_a[l*DATA_WID +: DATA_WID];
                    s0_w[l] <= wbuf[l][bus.rd_addr];
                end
            end
        end
    end

    // S1: full-width signed product per lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_clr   <= 1'b0;
            s1_state <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_prod[l] <= '0;
            end
        end else if (adv) begin
            s1_valid <= s0_valid;
            s1_mode  <= s0_mode;
            s1_clr   <= s0_clr;
            s1_state <= s0_state;
            for (int l = 0; l < LANES; l++) begin
                s1_prod[l] <= $signed({{DATA_WID{s0_a[l][DATA_WID-1]}}, s0_a[l]})
                            * $signed({{DATA_WID{s0_w[l][DATA_WID-1]}}, s0_w[l]});
            end
        end
    end

    // S2 datapath: rescale, saturate, and form the MAC sum one bit wider so
    // that overflow shows up as the top two bits disagreeing.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            shifted[l] = s1_prod[l] >>> FRAC_B;
            if (shifted[l] > P_MAX) begin
                prod_sat[l] = D_MAX;
            end else if (shifted[l] < P_MIN) begin
                prod_sat[l] = D_MIN;
            end else begin
                prod_sat[l] = shifted[l][DATA_WID-1:0];
            end
            acc_base[l] = s1_clr ? '0 : acc[l];
            sum[l] = {acc_base[l][DATA_WID-1], acc_base[l]}
                   + {prod_sat[l][DATA_WID-1], prod_sat[l]};
            if (sum[l][DATA_WID] != sum[l][DATA_WID-1]) begin
                mac_res[l] = sum[l][DATA_WID] ? D_MIN : D_MAX;
            end else begin
                mac_res[l] = sum[l][DATA_WID-1:0];
            end
            result[l] = s1_mode ? mac_res[l] : prod_sat[l];
        end
    end

    // Output register and accumulators. Accumulators only move when a valid
    // MAC word actually lands in the output register, so a stall can never
    // apply the same word twice. Bubbles clear the tag and leave data alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_state_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
            end
        end else if (adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_state_q <= s1_state;
                for (int l = 0; l < LANES; l++) begin
                    out_data_q[l*DATA_WID +: DATA_WID] <= result[l];
                    if (s1_mode) begin
                        acc[l] <= result[l];
                    end
                end
            end else begin
                out_state_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_buff_mult_arr_pipe.sv
// ---------------------------------------------------------------------------
// tb_buff_mult_arr_pipe
// Directed bench for buff_mult_arr_pipe. A behavioural model (per-lane weight
// arrays, integer accumulators, expected-result queue) predicts every output
// transfer; hand-computed lane values pin the model for each directed test.
// Inputs change 2 time units after a rising edge; the monitor samples on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_buff_mult_arr_pipe;

    localparam int DW      = 16;
    localparam int LANES   = 8;
    localparam int DEPTH   = 16;
    localparam int ADDR_B  = 4;
    localparam int FRAC_B  = 8;
    localparam int STATE_B = 3;
    localparam int VW      = LANES * DW;

    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    buff_mult_arr_pipe_if #(
        .DATA_WID(DW), .LANES(LANES), .ADDR_B(ADDR_B), .STATE_B(STATE_B)
    ) bus ();

    buff_mult_arr_pipe #(
        .DATA_WID(DW), .LANES(LANES), .DEPTH(DEPTH),
        .ADDR_B(ADDR_B), .FRAC_B(FRAC_B), .STATE_B(STATE_B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [VW-1:0]      data;
        logic [STATE_B-1:0] state;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t          exp_q [$];
    logic [VW-1:0] got_q [$];

    logic [DW-1:0]      mbuf [LANES][DEPTH];
    int                 macc [LANES];
    logic               stall_prev;
    logic [VW-1:0]      prev_data;
    logic [STATE_B-1:0] prev_state;

    logic [DW-1:0] sat_exp [3] = '{16'hFE00, 16'h7FFF, 16'h8000};
    logic [DW-1:0] mac_a   [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0500,
                                   16'h0100, 16'h0100, 16'h7000, 16'h7000};
    logic          mac_md  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic          mac_cl  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] mac_exp [8] = '{16'h0100, 16'h0300, 16'h0600, 16'h0500,
                                   16'h0700, 16'h0100, 16'h7000, 16'h7FFF};

    function automatic longint satD(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint mulScaled(input logic [DW-1:0] a, input logic [DW-1:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
        return satD(p >>> FRAC_B);
    endfunction

    function automatic logic [DW-1:0] laneA(input logic [DW-1:0] a, input int l);
        return a + DW'(l * 64);
    endfunction

    task automatic checkOutput(input string name, input logic [VW-1:0] act,
                               input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic checkLiteral(input string name, input int idx, input int lane,
                                input logic [DW-1:0] req);
        if (idx >= got_q.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: output %0d never arrived, required %h", name, idx, req);
        end else begin
            checkOutput(name, VW'(got_q[idx][lane*DW +: DW]), VW'(req));
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] a, input logic mode, input logic clr,
                                 input logic [STATE_B-1:0] st, input logic [ADDR_B-1:0] ra,
                                 input logic [LANES-1:0] wmask, input logic [ADDR_B-1:0] wa,
                                 input logic [DW-1:0] wd);
        logic took;
        int   tries;
        for (int l = 0; l < LANES; l++) begin
            bus.in_a[l*DW +: DW] = laneA(a, l);
        end
        bus.in_valid   = 1'b1;
        bus.in_mode    = mode;
        bus.in_acc_clr = clr;
        bus.in_state   = st;
        bus.rd_addr    = ra;
        bus.wr_en      = wmask;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        took  = 1'b0;
        tries = 0;
        while (!took && tries < 100) begin
            took = bus.in_ready;
            @(posedge clk);
            #2;
            bus.wr_en = '0;
            tries++;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic writeWord(input logic [LANES-1:0] mask, input logic [ADDR_B-1:0] addr,
                             input logic [DW-1:0] data);
        bus.wr_en   = mask;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk);
        #2;
        bus.wr_en = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput(name, VW'(exp_q.size()), '0);
    endtask

    // Monitor: checks handshake rules, stall stability and every transfer
    // against the model, then feeds the model with accepted words and writes.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            for (int l = 0; l < LANES; l++) begin
                macc[l] = 0;
                for (int d = 0; d < DEPTH; d++) mbuf[l][d] = '0;
            end
            stall_prev = 1'b0;
        end else begin
            checkOutput("in_ready_rule", VW'(bus.in_ready), VW'(!bus.out_valid || bus.out_ready));
            if (!bus.out_valid) checkOutput("bubble_state", VW'(bus.out_state), '0);
            if (stall_prev) begin
                checkOutput("stall_valid", VW'(bus.out_valid), VW'(1'b1));
                checkOutput("stall_data", bus.out_data, prev_data);
                checkOutput("stall_state", VW'(bus.out_state), VW'(prev_state));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h, required no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("model_data", bus.out_data, e.data);
                    checkOutput("model_state", VW'(bus.out_state), VW'(e.state));
                end
                got_q.push_back(bus.out_data);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_state = bus.out_state;
            if (bus.in_valid && bus.in_ready) begin
                e.state = bus.in_state;
                e.data  = '0;
                for (int l = 0; l < LANES; l++) begin
                    longint        m;
                    longint        r;
                    logic [DW-1:0] a_l;
                    a_l = bus.in_a[l*DW +: DW];
                    m = mulScaled(a_l, mbuf[l][bus.rd_addr]);
                    if (bus.in_mode) begin
                        r = satD((bus.in_acc_clr ? 64'sd0 : longint'(macc[l])) + m);
                        macc[l] = int'(r);
                    end else begin
                        r = m;
                    end
                    e.data[l*DW +: DW] = r[DW-1:0];
                end
                exp_q.push_back(e);
            end
            for (int l = 0; l < LANES; l++) begin
                if (bus.wr_en[l]) mbuf[l][bus.wr_addr] = bus.wr_data;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_mode    = 1'b0;
        bus.in_acc_clr = 1'b0;
        bus.in_state   = '0;
        bus.rd_addr    = '0;
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.out_ready  = 1'b1;
        reset          = 1'b0;

        #12;
        checkOutput("reset_valid", VW'(bus.out_valid), '0);
        checkOutput("reset_data", bus.out_data, '0);
        checkOutput("reset_state", VW'(bus.out_state), '0);
        #11 reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("reset_in_ready", VW'(bus.in_ready), VW'(1'b1));

        $display("[TB] basic MULT and latency");
        writeWord('1, 4'd3, 16'h0180);
        writeWord(8'hF0, 4'd3, 16'h0080);
        base = got_q.size();
        applyStimulus(16'h0200, 1'b0, 1'b0, 3'd2, 4'd3, '0, '0, '0);
        @(negedge clk);
        checkOutput("lat_cycle1", VW'(bus.out_valid), '0);
        @(negedge clk);
        checkOutput("lat_cycle2", VW'(bus.out_valid), '0);
        @(negedge clk);
        checkOutput("lat_cycle3_valid", VW'(bus.out_valid), VW'(1'b1));
        checkOutput("lat_cycle3_data0", VW'(bus.out_data[DW-1:0]), VW'(16'h0300));
        checkOutput("lat_cycle3_state", VW'(bus.out_state), VW'(3'd2));
        @(posedge clk);
        #2;
        drain("drain_basic");
        checkLiteral("basic_lane0", base, 0, 16'h0300);
        checkLiteral("basic_lane4", base, 4, 16'h0180);

        $display("[TB] sign and saturation");
        writeWord('1, 4'd1, 16'h0200);
        writeWord('1, 4'd2, 16'h7FFF);
        base = got_q.size();
        applyStimulus(16'hFF00, 1'b0, 1'b0, 3'd1, 4'd1, '0, '0, '0);
        applyStimulus(16'h7FFF, 1'b0, 1'b0, 3'd3, 4'd2, '0, '0, '0);
        applyStimulus(16'h8000, 1'b0, 1'b0, 3'd4, 4'd2, '0, '0, '0);
        drain("drain_sat");
        for (int k = 0; k < 3; k++) checkLiteral($sformatf("sat_%0d", k), base + k, 0, sat_exp[k]);
        checkLiteral("sat_neg_lane1", base, 1, 16'hFE80);

        $display("[TB] MAC sequence");
        writeWord('1, 4'd4, 16'h0100);
        base = got_q.size();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(mac_a[k], mac_md[k], mac_cl[k], 3'd5, 4'd4, '0, '0, '0);
        end
        drain("drain_mac");
        for (int k = 0; k < 8; k++) checkLiteral($sformatf("mac_%0d", k), base + k, 0, mac_exp[k]);

        $display("[TB] backpressure");
        base = got_q.size();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    applyStimulus(16'h0010, 1'b1, 1'(k == 0), 3'd6, 4'd4, '0, '0, '0);
                end
            end
            begin
                int n;
                n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checkOutput("bp_first_output", VW'(bus.out_valid), VW'(1'b1));
                bus.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready_low", VW'(bus.in_ready), '0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        checkOutput("bp_count", VW'(got_q.size() - base), VW'(6));
        for (int k = 0; k < 6; k++) begin
            checkLiteral($sformatf("bp_%0d", k), base + k, 0, DW'((k + 1) * 16));
        end

        $display("[TB] read/write collision");
        writeWord('1, 4'd5, 16'h0100);
        base = got_q.size();
        applyStimulus(16'h0100, 1'b0, 1'b0, 3'd7, 4'd5, '1, 4'd5, 16'h0400);
        applyStimulus(16'h0100, 1'b0, 1'b0, 3'd7, 4'd5, '0, '0, '0);
        drain("drain_coll");
        checkLiteral("coll_old", base, 0, 16'h0100);
        checkLiteral("coll_new", base + 1, 0, 16'h0400);

        $display("[TB] private lane buffers");
        writeWord(8'h0F, 4'd6, 16'h0200);
        writeWord(8'hF0, 4'd6, 16'h0300);
        base = got_q.size();
        applyStimulus(16'h0100, 1'b0, 1'b0, 3'd1, 4'd6, '0, '0, '0);
        drain("drain_priv");
        checkLiteral("priv_lane0", base, 0, 16'h0200);
        checkLiteral("priv_lane7", base, 7, 16'h0840);

        $display("[TB] asynchronous reset");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(16'h0100, 1'b1, 1'b0, 3'd2, 4'd4, '0, '0, '0);
        end
        checkOutput("pre_rst_valid", VW'(bus.out_valid), VW'(1'b1));
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_valid", VW'(bus.out_valid), '0);
        checkOutput("rst_data", bus.out_data, '0);
        checkOutput("rst_state", VW'(bus.out_state), '0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("post_rst_in_ready", VW'(bus.in_ready), VW'(1'b1));
        checkOutput("rst_flush", VW'(exp_q.size()), '0);
        base = got_q.size();
        applyStimulus(16'h0100, 1'b0, 1'b0, 3'd3, 4'd4, '0, '0, '0);
        writeWord('1, 4'd4, 16'h0100);
        applyStimulus(16'h0200, 1'b1, 1'b0, 3'd3, 4'd4, '0, '0, '0);
        drain("drain_rst");
        checkLiteral("rst_buf_cleared", base, 0, 16'h0000);
        checkLiteral("rst_acc_cleared", base + 1, 0, 16'h0200);

        repeat (3) begin
            @(posedge clk);
            #2;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buff_mult_arr_pipe.md
Name: buff_mult_arr_pipe

Overview:
Parametrised array of LANES buffer-multiplier lanes for the PE datapath. Each lane holds a private weight buffer and multiplies a per-lane input by the buffered word at a shared read address, with fixed-point rescaling and saturation. Each lane runs in multiply or multiply-accumulate mode. A valid/ready pipeline carries a PE state tag in lockstep with the data and supports output backpressure.

Parameters:
DATA_WID, 16, signed operand/result width
LANES, 8, number of parallel lanes
DEPTH, 16, words per lane buffer (power of 2)
ADDR_B, 4, buffer address width, log2(DEPTH)
FRAC_B, 8, fractional bits; product is arithmetic-shifted right by FRAC_B
STATE_B, 3, width of PE state tag (0 = INVALID)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input operand word valid
in_ready  out  1  pipeline can accept input
in_a  in  LANES*DATA_WID  signed per-lane operand A
in_mode  in  1  0 = MULT, 1 = MAC
in_acc_clr  in  1  MAC only: restart accumulator with this product
in_state  in  STATE_B  PE state tag
rd_addr  in  ADDR_B  shared buffer read address
wr_en  in  LANES  per-lane buffer write enable
wr_addr  in  ADDR_B  shared write address
wr_data  in  DATA_WID  write data, broadcast to enabled lanes
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_data  out  LANES*DATA_WID  signed per-lane result
out_state  out  STATE_B  tag aligned with out_data

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, out_state=0.
  - All internal stage valids=0; all accumulators=0; all buffer words=0.
  - in_ready=1 from the first edge after release.
- Advance signal: adv = !out_valid || out_ready. in_ready = adv. All stages move together only when adv=1; otherwise every stage register holds.
- Pipeline stages:
  - S0, accept: on in_valid && adv, register in_a, mode, acc_clr and state, and synchronously read buffer[rd_addr] per lane.
  - S1, multiply: full 2*DATA_WID signed product per lane.
  - S2, output: shift the product right arithmetically by FRAC_B (truncation toward -inf), then compute the result below and register it to out_*.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput: 1 word/cycle.
- Bubbles: S0 captures in_valid=0 as an invalid bubble. Bubbles never touch accumulators or outputs beyond out_valid=0 on advance.
- MULT result: saturate(shifted) to [-2^(DATA_WID-1), 2^(DATA_WID-1)-1].
- MAC result:
  - sum = (acc_clr ? 0 : acc) + saturate(shifted), computed at DATA_WID+1 bits.
  - Result = saturate(sum). acc <= result; out_data = result.
  - The accumulator updates only when a valid word advances into the output register.
- MULT words leave the accumulators unchanged.
- A MAC word without acc_clr after reset accumulates onto 0.
- Buffer write:
  - Independent of the handshake; never stalled.
  - On any cycle, each lane with wr_en[i]=1 stores wr_data at wr_addr.
- Read/write collision: a read at the same address and cycle as a write returns the OLD word (read-before-write).
- out_state is the in_state of the same word. Bubbles output out_state=0.
- While out_valid=1 && out_ready=0, out_data and out_state are held stable.
- Reset mid-operation: in-flight words are discarded and accumulators are cleared. The buffer is cleared, so it must be reloaded.

Test Plan:
- Basic MULT: DATA_WID=16, FRAC_B=8. Write lane0 addr3=0x0180. Send A0=0x0200 (2.0) with rd_addr=3, state=2. Required: 3 cycles later out_data[0]=0x0300 and out_state=2.
- Sign and saturation:
  - A=0xFF00 (-1.0), W=0x0200 -> 0xFE00.
  - A=0x7FFF, W=0x7FFF -> 0x7FFF (positive saturation).
  - A=0x8000, W=0x7FFF -> 0x8000 (negative saturation).
- MAC sequence: W=0x0100. Send A=0x0100 with clr=1, then A=0x0200, then A=0x0300 (MAC). Required outputs: 0x0100, 0x0300, 0x0600. Then A=0x0100 with clr=1 -> 0x0100. Then 0x7000+0x7000 -> 0x7FFF.
- Backpressure: stream 6 words; hold out_ready=0 for 4 cycles after the first output. Required:
  - in_ready=0 while out_valid=1 and out_ready=0.
  - out_data stable during the stall.
  - All 6 results arrive in order; nothing is lost or duplicated; accumulators are not double-updated.
- Collision: write addr5=0x0400 in the same cycle a word is accepted with rd_addr=5 (old word 0x0100), A=0x0100. Required: result 0x0100. The next read of addr5 yields 0x0400.
- Async reset: assert reset low mid-stream, asynchronously to clk. Required: out_valid, out_data and out_state drop to 0 immediately. After release, MAC with clr=0 starts from 0, and a buffer read returns 0.
